// File: rtl/std_cache_pkg.sv
// Shared types and width helpers for the data-cache SRAM scheduler.
// Holds the scheduler state encoding and the counter-width functions so that
// every file sizes its counters the same way.
package std_cache_pkg;

    // Scheduler modes: clearing the valid/dirty array, or arbitrating requesters.
    typedef enum logic {
        SWEEP = 1'b0,
        ARB   = 1'b1
    } sched_state_e;

    // Width of the sweep index counter (counts 0..num_words-1).
    function automatic int unsigned sweep_cnt_w(input int unsigned num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    // Width of the starvation counter (counts 0..limit inclusive).
    function automatic int unsigned starve_cnt_w(input int unsigned limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

    // Width of the round-robin pointer (holds a port index 1..n-1).
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_sram_sched_rr_pick.sv
// Round-robin search: returns the first set mask bit at or after the pointer,
// wrapping around, as a one-hot vector (all zero when the mask is empty).
module rr_pick
    import std_cache_pkg::*;
#(
    parameter int unsigned N  = 5,
    parameter int unsigned PW = 3
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  winner
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Walk the ports starting at the pointer and keep the first requester seen.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, pointer} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && mask[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_sram_sched.sv
// Data-cache SRAM scheduler: after reset (or an init request) sweeps every
// index writing zeros to clear valid/dirty state, then arbitrates one port per
// cycle onto the shared SRAM command. Port 0 (miss handler) has priority;
// the other ports share round-robin.
// Optional feature macro: DCACHE_SRAM_SCHED_STARVE_EN -- when defined, a
// round-robin requester that has lost to port 0 STARVE_LIMIT cycles in a row
// beats port 0 for one cycle.
module dcache_sram_sched
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS     = 5,
    parameter int unsigned SET_ASSOC    = 8,
    parameter int unsigned INDEX_WIDTH  = 12,
    parameter int unsigned NUM_WORDS    = 256,
    parameter int unsigned LINE_WIDTH   = 128,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    init_ni,
    input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]      req_i,
    input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0]    addr_i,
    input  logic [NR_PORTS-1:0]                     we_i,
    input  logic [NR_PORTS-1:0][LINE_WIDTH-1:0]     wdata_i,
    input  logic [NR_PORTS-1:0][LINE_WIDTH/8-1:0]   be_i,
    output logic [NR_PORTS-1:0]                     gnt_o,
    output logic [NR_PORTS-1:0]                     rvalid_o,
    output logic                                    busy_o,
    output logic [SET_ASSOC-1:0]                    req_ram_o,
    output logic [INDEX_WIDTH-1:0]                  addr_ram_o,
    output logic                                    we_ram_o,
    output logic [LINE_WIDTH-1:0]                   wdata_ram_o,
    output logic [LINE_WIDTH/8-1:0]                 be_ram_o
);

    localparam int unsigned BE_WIDTH = LINE_WIDTH / 8;
    localparam int unsigned OFFSET   = INDEX_WIDTH - $clog2(NUM_WORDS);
    localparam int unsigned CNT_W    = sweep_cnt_w(NUM_WORDS);
    localparam int unsigned PTR_W    = ptr_w(NR_PORTS);

    sched_state_e         state_q;
    logic [CNT_W-1:0]     sweep_cnt_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_next;
    logic [NR_PORTS-1:0]  rvalid_q;

    logic [NR_PORTS-1:0]  req_any;
    logic [NR_PORTS-1:0]  rr_mask;
    logic [NR_PORTS-1:0]  rr_gnt;
    logic                 rr_any;
    logic                 rr_granted;
    logic                 starve_win;

    // Collapse each port's way mask into a single "this port requests" bit.
    always_comb begin
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            req_any[p] = |req_i[p];
        end
        rr_mask    = req_any;
        rr_mask[0] = 1'b0;
        rr_any     = |rr_mask;
    end

    rr_pick #(
        .N  (NR_PORTS),
        .PW (PTR_W)
    ) u_rr_pick (
        .mask    (rr_mask),
        .pointer (ptr_q),
        .winner  (rr_gnt)
    );

`ifdef DCACHE_SRAM_SCHED_STARVE_EN
    localparam int unsigned STARVE_W = starve_cnt_w(STARVE_LIMIT);
    logic [STARVE_W-1:0] starve_cnt_q;

    // Round-robin side gets one forced win after STARVE_LIMIT straight losses.
    assign starve_win = (starve_cnt_q == STARVE_W'(STARVE_LIMIT)) && rr_any;

    // Count consecutive losses to port 0; any round-robin grant clears it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else if (rr_granted) begin
            starve_cnt_q <= '0;
        end else if (gnt_o[0] && rr_any) begin
            starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
        end
    end
`else
    assign starve_win = 1'b0;
`endif

    // Grant at most one port, only while arbitrating and not re-initialising.
    always_comb begin
        gnt_o = '0;
        if ((state_q == ARB) && init_ni) begin
            if (req_any[0] && !starve_win) begin
                gnt_o[0] = 1'b1;
            end else begin
                gnt_o = rr_gnt;
            end
        end
    end

    assign rr_granted = |gnt_o[NR_PORTS-1:1];

    // Pointer moves to one past the round-robin winner, skipping port 0.
    always_comb begin
        ptr_next = ptr_q;
        for (int unsigned p = 1; p < NR_PORTS; p++) begin
            if (rr_gnt[p]) begin
                ptr_next = (p == NR_PORTS - 1) ? PTR_W'(1) : PTR_W'(p + 1);
            end
        end
    end

    // Drive the shared SRAM command from the sweep or from the granted port.
    always_comb begin
        req_ram_o   = '0;
        addr_ram_o  = '0;
        we_ram_o    = 1'b0;
        wdata_ram_o = '0;
        be_ram_o    = '0;
        if (state_q == SWEEP) begin
            req_ram_o  = '1;
            addr_ram_o = INDEX_WIDTH'(sweep_cnt_q) << OFFSET;
            we_ram_o   = 1'b1;
            be_ram_o   = {BE_WIDTH{1'b1}};
        end else begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (gnt_o[p]) begin
                    req_ram_o   = req_i[p];
                    addr_ram_o  = addr_i[p];
                    we_ram_o    = we_i[p];
                    wdata_ram_o = wdata_i[p];
                    be_ram_o    = be_i[p];
                end
            end
        end
    end

    // Scheduler FSM: sweep counter, round-robin pointer and read-valid pipeline.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            state_q     <= SWEEP;
            sweep_cnt_q <= '0;
            ptr_q       <= PTR_W'(1);
            rvalid_q    <= '0;
        end else begin
            rvalid_q <= gnt_o & ~we_i;
            if (rr_granted) begin
                ptr_q <= ptr_next;
            end
            if (!init_ni) begin
                state_q     <= SWEEP;
                sweep_cnt_q <= '0;
            end else if (state_q == SWEEP) begin
                if (sweep_cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                    state_q <= ARB;
                end else begin
                    sweep_cnt_q <= sweep_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign busy_o   = (state_q == SWEEP);

endmodule

// File: tb/tb_dcache_sram_sched.sv
// Self-checking bench for dcache_sram_sched: randomized and directed stimulus
// against a behavioural model; read-valid responses go through a scoreboard
// queue checked by an independent monitor.
module tb_dcache_sram_sched;

    localparam int NR_PORTS     = 5;
    localparam int SET_ASSOC    = 8;
    localparam int INDEX_WIDTH  = 12;
    localparam int NUM_WORDS    = 256;
    localparam int LINE_WIDTH   = 128;
    localparam int BE_WIDTH     = LINE_WIDTH / 8;
    localparam int STARVE_LIMIT = 4;

    logic clk;
    logic rst_n;
    logic init_n;
    logic [NR_PORTS-1:0][SET_ASSOC-1:0]   req;
    logic [NR_PORTS-1:0][INDEX_WIDTH-1:0] addr;
    logic [NR_PORTS-1:0]                  we;
    logic [NR_PORTS-1:0][LINE_WIDTH-1:0]  wdata;
    logic [NR_PORTS-1:0][BE_WIDTH-1:0]    be;
    logic [NR_PORTS-1:0]                  gnt_o;
    logic [NR_PORTS-1:0]                  rvalid_o;
    logic                                 busy_o;
    logic [SET_ASSOC-1:0]                 req_ram_o;
    logic [INDEX_WIDTH-1:0]               addr_ram_o;
    logic                                 we_ram_o;
    logic [LINE_WIDTH-1:0]                wdata_ram_o;
    logic [BE_WIDTH-1:0]                  be_ram_o;

    dcache_sram_sched #(
        .NR_PORTS     (NR_PORTS),
        .SET_ASSOC    (SET_ASSOC),
        .INDEX_WIDTH  (INDEX_WIDTH),
        .NUM_WORDS    (NUM_WORDS),
        .LINE_WIDTH   (LINE_WIDTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .init_ni     (init_n),
        .req_i       (req),
        .addr_i      (addr),
        .we_i        (we),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .busy_o      (busy_o),
        .req_ram_o   (req_ram_o),
        .addr_ram_o  (addr_ram_o),
        .we_ram_o    (we_ram_o),
        .wdata_ram_o (wdata_ram_o),
        .be_ram_o    (be_ram_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int cyc;
        int port;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    bit m_sweep;
    int m_idx;
    int m_ptr;
    int m_starve;

    int busy_run;
    int gnt_cnt [NR_PORTS];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic clear_inputs();
        req   = '0;
        addr  = '0;
        we    = '0;
        wdata = '0;
        be    = '0;
    endtask

    task automatic set_port(input int p, input logic [SET_ASSOC-1:0] m, input logic w,
                            input logic [INDEX_WIDTH-1:0] a);
        req[p]   = m;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = {$urandom, $urandom, $urandom, $urandom};
        be[p]    = '1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_sweep  = 1'b1;
        m_idx    = 0;
        m_ptr    = 1;
        m_starve = 0;
    endtask

    // One clock cycle: inputs already applied; check mid-cycle, advance model.
    task automatic step();
        int  win;
        int  rr_win;
        int  p;
        bit  p0_req;
        bit  force_rr;
        logic [NR_PORTS-1:0] e_gnt;
        @(negedge clk);
        if (busy_o === 1'b1) busy_run++;
        for (int i = 0; i < NR_PORTS; i++) if (gnt_o[i] === 1'b1) gnt_cnt[i]++;
        if (m_sweep) begin
            check("busy_sweep", busy_o, 1);
            check("gnt_sweep", gnt_o, 0);
            check("sweep_req", req_ram_o, 8'hFF);
            check("sweep_we", we_ram_o, 1);
            check("sweep_addr", addr_ram_o, 128'(m_idx * 16));
            check("sweep_wdata", wdata_ram_o, 0);
            check("sweep_be", be_ram_o, 16'hFFFF);
            if (!init_n) m_idx = 0;
            else if (m_idx == NUM_WORDS - 1) m_sweep = 1'b0;
            else m_idx++;
        end else begin
            check("busy_arb", busy_o, 0);
            p0_req = |req[0];
            rr_win = -1;
            for (int k = 0; k < NR_PORTS - 1; k++) begin
                p = 1 + ((m_ptr - 1 + k) % (NR_PORTS - 1));
                if (rr_win < 0 && (|req[p])) rr_win = p;
            end
            force_rr = 1'b0;
`ifdef DCACHE_SRAM_SCHED_STARVE_EN
            force_rr = (m_starve >= STARVE_LIMIT) && (rr_win > 0);
`endif
            if (!init_n) win = -1;
            else if (p0_req && !force_rr) win = 0;
            else win = rr_win;
            e_gnt = (win >= 0) ? (NR_PORTS'(1) << win) : '0;
            check("gnt", gnt_o, e_gnt);
            if (win >= 0) begin
                check("ram_req", req_ram_o, req[win]);
                check("ram_addr", addr_ram_o, addr[win]);
                check("ram_we", we_ram_o, we[win]);
                check("ram_wdata", wdata_ram_o, wdata[win]);
                check("ram_be", be_ram_o, be[win]);
                if (!we[win]) exp_q.push_back('{cyc + 1, win});
            end else begin
                check("idle_req_ram", req_ram_o, 0);
                check("idle_we", we_ram_o, 0);
            end
            if (win > 0) begin
                m_ptr    = (win == NR_PORTS - 1) ? 1 : win + 1;
                m_starve = 0;
            end else if (win == 0 && rr_win > 0) begin
                m_starve++;
            end
            if (!init_n) begin
                m_sweep = 1'b1;
                m_idx   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (m_sweep && n < budget) begin
            step();
            n++;
        end
        check("sweep_terminated", m_sweep, 0);
    endtask

    // Monitor: compares read-valid outputs against the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("rvalid_missing", 0, NR_PORTS'(1) << e.port);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("rvalid", rvalid_o, NR_PORTS'(1) << e.port);
            end else begin
                check("rvalid_idle", rvalid_o, 0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_p2;
        rst_n  = 1'b0;
        init_n = 1'b1;
        clear_inputs();
        for (int i = 0; i < NR_PORTS; i++) gnt_cnt[i] = 0;

        // Reset release with no requests: full sweep then idle.
        do_reset();
        busy_run = 0;
        run_until_idle(600);
        check("sweep_len_reset", busy_run, NUM_WORDS);
        step();
        step();

        // Port 0 and port 2 continuously requesting reads.
        set_port(0, 8'h01, 1'b0, 12'h100);
        set_port(2, 8'h04, 1'b0, 12'h200);
        for (int i = 0; i < NR_PORTS; i++) gnt_cnt[i] = 0;
        for (int i = 0; i < 15; i++) step();
`ifdef DCACHE_SRAM_SCHED_STARVE_EN
        exp_p2 = 3;
`else
        exp_p2 = 0;
`endif
        check("p2_grants_vs_p0", gnt_cnt[2], exp_p2);
        check("p0_grants_vs_p2", gnt_cnt[0], 15 - exp_p2);

        // Ports 1, 2, 3 continuously reading: round-robin rotation.
        clear_inputs();
        set_port(1, 8'h10, 1'b0, 12'h010);
        set_port(2, 8'h20, 1'b0, 12'h020);
        set_port(3, 8'h40, 1'b0, 12'h030);
        for (int i = 0; i < NR_PORTS; i++) gnt_cnt[i] = 0;
        for (int i = 0; i < 12; i++) step();
        check("rr_p1_share", gnt_cnt[1], 4);
        check("rr_p3_share", gnt_cnt[3], 4);

        // Port 4 write to 0x2A0 with all byte enables.
        clear_inputs();
        set_port(4, 8'h80, 1'b1, 12'h2A0);
        step();
        clear_inputs();
        step();

        // Randomized traffic with occasional init pulses.
        for (int i = 0; i < 700; i++) begin
            clear_inputs();
            for (int p = 0; p < NR_PORTS; p++) begin
                if ($urandom_range(0, (p == 0) ? 2 : 1) == 0) begin
                    set_port(p, SET_ASSOC'($urandom_range(1, 255)), 1'($urandom_range(0, 1)),
                             INDEX_WIDTH'($urandom));
                    be[p] = BE_WIDTH'($urandom);
                end
            end
            init_n = ($urandom_range(0, 149) != 0);
            step();
        end
        init_n = 1'b1;
        clear_inputs();
        run_until_idle(600);

        // Reset while reads are being granted: pending reads are abandoned.
        set_port(1, 8'h01, 1'b0, 12'h111);
        set_port(3, 8'h02, 1'b0, 12'h333);
        step();
        do_reset();

        // Init pulse at sweep index 100 restarts the sweep from index 0.
        for (int i = 0; i < 100; i++) step();
        check("model_idx_at_pulse", m_idx, 100);
        init_n = 1'b0;
        step();
        init_n = 1'b1;
        busy_run = 0;
        run_until_idle(600);
        check("sweep_len_after_init", busy_run, NUM_WORDS);

        // Drain and finish.
        for (int i = 0; i < 3; i++) step();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_sram_sched.md
DCACHE_SRAM_SCHED -- requirements
Module: dcache_sram_sched

Interface
REQ-001 SHALL have parameter NR_PORTS, default 5, number of requesters; port 0 is the miss handler.
REQ-002 SHALL have parameter SET_ASSOC, default 8, number of ways.
REQ-003 SHALL have parameter INDEX_WIDTH, default 12, SRAM address width in bytes of index.
REQ-004 SHALL have parameter NUM_WORDS, default 256, lines per way; OFFSET = INDEX_WIDTH - $clog2(NUM_WORDS).
REQ-005 SHALL have parameter LINE_WIDTH, default 128, line data width; BE_WIDTH = LINE_WIDTH/8.
REQ-006 SHALL have parameter STARVE_LIMIT, default 4, consecutive cycles a round-robin requester may lose to port 0.
REQ-007 SHALL have port clk_i  in  1  the one clock; rising edge.
REQ-008 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-009 SHALL have port init_ni  in  1  active-low request to re-clear the valid/dirty state.
REQ-010 SHALL have port req_i  in  NR_PORTS x SET_ASSOC  per-port way request mask; any bit set means port requests.
REQ-011 SHALL have port addr_i  in  NR_PORTS x INDEX_WIDTH  per-port address.
REQ-012 SHALL have port we_i  in  NR_PORTS  per-port write enable.
REQ-013 SHALL have port wdata_i  in  NR_PORTS x LINE_WIDTH  per-port write data.
REQ-014 SHALL have port be_i  in  NR_PORTS x BE_WIDTH  per-port byte enables.
REQ-015 SHALL have port gnt_o  in/out: out  NR_PORTS  one-hot-or-zero grant, same cycle as request.
REQ-016 SHALL have port rvalid_o  out  NR_PORTS  read data valid, one cycle after a read grant.
REQ-017 SHALL have port busy_o  out  1  high while the clear sweep runs.
REQ-018 SHALL have ports req_ram_o (SET_ASSOC), addr_ram_o (INDEX_WIDTH), we_ram_o (1), wdata_ram_o (LINE_WIDTH), be_ram_o (BE_WIDTH)  out  shared SRAM command.

Function
REQ-019 SHALL implement FSM states SWEEP and ARB; SWEEP entered on reset and on any cycle init_ni=0 (restart at index 0).
REQ-020 In SWEEP SHALL issue one write per cycle: req_ram_o all ones, we_ram_o=1, wdata_ram_o=0, be_ram_o all ones, addr_ram_o = count << OFFSET, low OFFSET bits zero.
REQ-021 SWEEP SHALL last exactly NUM_WORDS cycles (count 0..NUM_WORDS-1, no wrap), then go to ARB; gnt_o=0 and busy_o=1 throughout.
REQ-022 In ARB SHALL grant at most one port per cycle, combinationally, and drive SRAM command from the winner; with no request req_ram_o=0, we_ram_o=0.
REQ-023 Port 0 SHALL win whenever requesting, except under REQ-026.
REQ-024 Ports 1..NR_PORTS-1 SHALL be served round-robin starting search at pointer; pointer SHALL move to one past the granted port (wrapping NR_PORTS-1 to 1) only on a round-robin grant.
REQ-025 rvalid_o[p] SHALL be 1 in cycle N+1 iff port p received a grant with we_i[p]=0 in cycle N; zero otherwise.
REQ-026 Starvation counter SHALL increment each cycle a round-robin port requests but port 0 wins; at STARVE_LIMIT the round-robin winner SHALL beat port 0 that cycle; counter SHALL clear on any round-robin grant.
REQ-027 init_ni=0 in the same cycle as requests SHALL suppress all grants; a pending rvalid from the previous cycle SHALL still be delivered.

Reset
REQ-028 On rst_ni=0 at a clock edge: state=SWEEP, count=0, pointer=1, starvation counter=0, rvalid_o=0; busy_o=1 the following cycle.
REQ-029 Reset asserted mid-sweep or mid-grant SHALL abandon the operation and restart the sweep at index 0.

Configuration
REQ-030 Macro DCACHE_SRAM_SCHED_STARVE_EN defined: REQ-026 active; undefined: counter absent, port 0 has strict priority always.

Structure
REQ-031 State enum and sweep/starve counter widths SHALL live in std_cache_pkg; round-robin search SHALL be a sub-module rr_pick (mask, pointer -> one-hot winner).

Verification
REQ-032 Reset release, no requests -> busy_o=1 for 256 cycles, addresses 0x000,0x010..0xFF0, then busy_o=0.
REQ-033 Ports 1,2,3 request reads continuously -> grants 1,2,3,1,... and rvalid_o follows each grant by one cycle.
REQ-034 Port 0 and port 2 request continuously, macro defined -> port 0 granted 4 cycles, port 2 on 5th, repeat; macro undefined -> port 2 never granted.
REQ-035 init_ni pulsed low at sweep count 100 -> sweep restarts at index 0, total busy 256 cycles after pulse.
REQ-036 Port 4 write addr 0x2A0, be all ones -> gnt_o[4]=1 same cycle, we_ram_o=1, addr_ram_o=0x2A0, no rvalid_o.
